pixel_combinator: RTL and testbench
===================================

PIXEL_COMBINATOR -- requirements
Module: pixel_combinator

Interface
REQ-001 Parameters: DATA_WIDTH, 32, coordinate width; RBG_SIZE, 24, colour width; NUM_QUEUES, 4, number of engine queues; IMG_WIDTH, 640, pixels per line; IMG_HEIGHT, 480, lines per frame; TIMEOUT, 1024, max SEEK cycles per pixel.
REQ-002 Ports SHALL be:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a frame from IDLE
- check_x  out  DATA_WIDTH  x coordinate broadcast to all queues, registered
- check_y  out  DATA_WIDTH  y coordinate broadcast to all queues, registered
- q_hit  in  NUM_QUEUES  bit i high one cycle after queue i popped a head matching check_x/check_y
- q_colour  in  NUM_QUEUES*RBG_SIZE  colour of queue i at bits [i*RBG_SIZE +: RBG_SIZE], valid with q_hit[i]
- pix_colour  out  RBG_SIZE  output pixel colour
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream accepts pixel
- pix_sof  out  1  pixel is (0,0), qualified by pix_valid
- pix_eol  out  1  pixel has x == IMG_WIDTH-1, qualified by pix_valid
- frame_done  out  1  one-cycle pulse after last pixel of frame accepted
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky, a pixel was substituted after TIMEOUT
- hit_err  out  1  sticky, multiple or stray q_hit seen

Function
REQ-003 States: IDLE, SEEK, OUT; encoding free.
REQ-004 PARK coordinate = 32'hFFFF_FFFE on both check_x and check_y; never all-ones (queue empty-slot value), never an in-frame coordinate.
REQ-005 IDLE: check = PARK; start -> check = (0,0), timeout counter = 0, state SEEK next cycle.
REQ-006 SEEK: check held at current raster (x,y); counter increments each cycle without hit.
REQ-007 SEEK, any q_hit bit set: pix_colour <= q_colour of lowest set index, pix_valid <= 1, pix_sof/pix_eol from current (x,y), check <= PARK, state OUT.
REQ-008 SEEK, more than one q_hit bit set in same cycle: REQ-007 applies, hit_err <= 1.
REQ-009 SEEK, no hit and counter == TIMEOUT-1: pix_colour <= 0, pix_valid <= 1, timeout_err <= 1, check <= PARK, state OUT; hit on same edge wins over timeout (no timeout_err).
REQ-010 OUT: pix_valid and all pix_* stable until pix_ready; q_hit nonzero in OUT or IDLE sets hit_err, data discarded.
REQ-011 OUT with pix_ready: pix_valid <= 0; if x < IMG_WIDTH-1 then x+1; else x = 0, y+1; counter = 0; check <= new (x,y); state SEEK.
REQ-012 OUT with pix_ready at (IMG_WIDTH-1, IMG_HEIGHT-1): pix_valid <= 0, frame_done = 1 for one cycle, raster = (0,0), check = PARK, state IDLE.
REQ-013 Minimum per-pixel latency: coordinate visible cycle N, hit sampled edge N+1, pix_valid high cycle N+2; with pix_ready tied high, one pixel per 3 cycles max.
REQ-014 start outside IDLE ignored; start same cycle as frame_done pulse ignored (state still OUT at that edge).
REQ-015 Coordinates compared/stored at full DATA_WIDTH; raster counters never exceed IMG_WIDTH-1 / IMG_HEIGHT-1.

Reset
REQ-016 reset SHALL dominate all other inputs in any state, including mid-frame.
REQ-017 Reset values: state IDLE, raster (0,0), counter 0, check_x/check_y = PARK, pix_valid 0, pix_colour 0, pix_sof 0, pix_eol 0, frame_done 0, busy 0, timeout_err 0, hit_err 0.
REQ-018 Sticky errors cleared only by reset.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, NUM_QUEUES=2, TIMEOUT=8)
REQ-019 start, model queues answer each coordinate with q_hit=2'b01 one cycle later, pix_ready=1 -> 8 pixels in raster order, sof on pixel 0 only, eol on pixels 3 and 7, frame_done once, busy low after.
REQ-020 q_hit=2'b11 colours 24'h111111 / 24'h222222 -> pix_colour 24'h111111, hit_err=1.
REQ-021 No hit for coordinate (2,0) -> pix_valid after 8 SEEK cycles with colour 0, timeout_err=1, frame completes.
REQ-022 pix_ready low 5 cycles with pixel (1,1) pending -> pix_* stable, check = PARK throughout, advance to (2,1) on the accept cycle.
REQ-023 reset asserted in OUT at (3,0) -> next cycle state IDLE, check = PARK, pix_valid 0; subsequent start restarts at (0,0).
REQ-024 start pulses during SEEK and OUT -> no effect on raster or state.

Source files
------------

// File: rtl/pixel_combinator.sv
// rtl/pixel_combinator.sv - raster pixel combinator over a set of engine queues
//
// Purpose: walks the frame in raster order. For each pixel it broadcasts the
// coordinate to all engine queues, waits for a queue to report a hit, and
// emits that queue's colour downstream with valid/ready handshaking. If no
// hit arrives within TIMEOUT cycles, a black pixel is substituted.
//
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   start                one-cycle pulse, starts a frame from IDLE
//   check_x, check_y     registered coordinate broadcast (PARK when not seeking)
//   q_hit, q_colour      per-queue hit flag and colour, one cycle after the match
//   pix_colour/valid     output pixel, held until pix_ready
//   pix_ready            downstream accept
//   pix_sof, pix_eol     start of frame / end of line markers, qualified by valid
//   frame_done           high in the cycle the last pixel of the frame is accepted
//   busy                 state != IDLE
//   timeout_err, hit_err sticky error flags, cleared only by reset
module pixel_combinator #(
  parameter int DATA_WIDTH = 32,
  parameter int RBG_SIZE   = 24,
  parameter int NUM_QUEUES = 4,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic [DATA_WIDTH-1:0]          check_x,
  output logic [DATA_WIDTH-1:0]          check_y,
  input  logic [NUM_QUEUES-1:0]          q_hit,
  input  logic [NUM_QUEUES*RBG_SIZE-1:0] q_colour,
  output logic [RBG_SIZE-1:0]            pix_colour,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic                           pix_sof,
  output logic                           pix_eol,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           timeout_err,
  output logic                           hit_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Parking coordinate: never all-ones (empty queue slot) and never in-frame.
  localparam logic [DATA_WIDTH-1:0] PARK   = DATA_WIDTH'(32'hFFFF_FFFE);
  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(IMG_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_OUT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_x, r_y;
  logic [DATA_WIDTH-1:0] r_check_x, r_check_y;
  logic [CNT_W-1:0]      r_cnt;
  logic [RBG_SIZE-1:0]   r_pix_colour;
  logic                  r_pix_valid, r_pix_sof, r_pix_eol;
  logic                  r_timeout_err, r_hit_err;

  logic                  w_any_hit, w_multi_hit, w_timeout, w_last, w_eol;
  logic [RBG_SIZE-1:0]   w_sel_colour;
  logic [DATA_WIDTH-1:0] w_nx, w_ny;

  assign w_any_hit   = |q_hit;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi_hit = (q_hit & (q_hit - NUM_QUEUES'(1))) != '0;
  assign w_timeout   = (r_cnt == CNT_LAST);
  assign w_eol       = (r_x == X_LAST);
  assign w_last      = w_eol && (r_y == Y_LAST);
  assign w_nx        = w_eol ? '0 : r_x + DATA_WIDTH'(1);
  assign w_ny        = w_eol ? r_y + DATA_WIDTH'(1) : r_y;

  // Lowest-index hit wins: scan downwards so the last assignment is the lowest.
  always_comb begin
    w_sel_colour = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (q_hit[i]) w_sel_colour = q_colour[i*RBG_SIZE +: RBG_SIZE];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SEEK;
      S_SEEK:  if (w_any_hit || w_timeout) w_state_nxt = S_OUT;
      S_OUT:   if (pix_ready) w_state_nxt = w_last ? S_IDLE : S_SEEK;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic; frame_done is combinational so it coincides with the final
  // accept edge, which is why a start in that cycle still sees state OUT.
  always_comb begin
    busy       = (r_state != S_IDLE);
    frame_done = (r_state == S_OUT) && pix_ready && w_last;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_cnt         <= '0;
      r_check_x     <= PARK;
      r_check_y     <= PARK;
      r_pix_colour  <= '0;
      r_pix_valid   <= 1'b0;
      r_pix_sof     <= 1'b0;
      r_pix_eol     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_hit_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_hit) r_hit_err <= 1'b1;
          if (start) begin
            r_check_x <= '0;
            r_check_y <= '0;
            r_cnt     <= '0;
          end
        end
        S_SEEK: begin
          if (w_any_hit || w_timeout) begin
            r_pix_colour <= w_any_hit ? w_sel_colour : '0;
            r_pix_valid  <= 1'b1;
            r_pix_sof    <= (r_x == '0) && (r_y == '0);
            r_pix_eol    <= w_eol;
            r_check_x    <= PARK;
            r_check_y    <= PARK;
            if (w_multi_hit) r_hit_err <= 1'b1;
            if (!w_any_hit)  r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (w_any_hit) r_hit_err <= 1'b1;
          if (pix_ready) begin
            r_pix_valid <= 1'b0;
            r_pix_sof   <= 1'b0;
            r_pix_eol   <= 1'b0;
            r_cnt       <= '0;
            if (w_last) begin
              r_x       <= '0;
              r_y       <= '0;
              r_check_x <= PARK;
              r_check_y <= PARK;
            end else begin
              r_x       <= w_nx;
              r_y       <= w_ny;
              r_check_x <= w_nx;
              r_check_y <= w_ny;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign check_x     = r_check_x;
  assign check_y     = r_check_y;
  assign pix_colour  = r_pix_colour;
  assign pix_valid   = r_pix_valid;
  assign pix_sof     = r_pix_sof;
  assign pix_eol     = r_pix_eol;
  assign timeout_err = r_timeout_err;
  assign hit_err     = r_hit_err;

endmodule

// File: tb/tb_pixel_combinator.sv
// tb/tb_pixel_combinator.sv - randomized self-checking bench for pixel_combinator
module tb_pixel_combinator;

  localparam int DW = 32, CW = 24, NQ = 2, IW = 4, IH = 2, TO = 8;
  localparam int NPIX = IW * IH;
  localparam logic [31:0] PARK = 32'hFFFF_FFFE;

  logic clk = 1'b0;
  logic reset, start, pix_ready;
  logic [NQ-1:0] q_hit;
  logic [NQ*CW-1:0] q_colour;
  logic [DW-1:0] check_x, check_y;
  logic [CW-1:0] pix_colour;
  logic pix_valid, pix_sof, pix_eol, frame_done, busy, timeout_err, hit_err;

  always #5 clk = ~clk;

  pixel_combinator #(
    .DATA_WIDTH(DW), .RBG_SIZE(CW), .NUM_QUEUES(NQ),
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .check_x(check_x), .check_y(check_y),
    .q_hit(q_hit), .q_colour(q_colour),
    .pix_colour(pix_colour), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
    .busy(busy), .timeout_err(timeout_err), .hit_err(hit_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame plan: which queues answer each raster pixel, and with what colour.
  logic [1:0]  plan_mask [NPIX];
  logic [23:0] plan_c0   [NPIX];
  logic [23:0] plan_c1   [NPIX];
  bit          plan_valid = 0;
  int          gen = 0;
  bit          mon_en = 0;
  logic [1:0]  inj = 2'b00;
  bit          exp_terr = 0, exp_herr = 0;

  function automatic logic [23:0] exp_colour(input int k);
    if (plan_mask[k] == 2'b00) return 24'h0;
    if (plan_mask[k][0])       return plan_c0[k];
    return plan_c1[k];
  endfunction

  // Engine queue model: a queue pops its head when the broadcast coordinate
  // matches it, and reports the hit during the following cycle.
  typedef struct { logic [31:0] x; logic [31:0] y; logic [23:0] c; } ent_t;
  ent_t q0[$];
  ent_t q1[$];
  int m_gen = 0;
  logic [1:0]  pend_hit = 2'b00;
  logic [47:0] pend_col = '0;

  initial forever begin
    @(negedge clk);
    if (gen != m_gen) begin
      m_gen = gen;
      q0.delete();
      q1.delete();
      if (plan_valid) begin
        for (int k = 0; k < NPIX; k++) begin
          ent_t e;
          e.x = 32'(k % IW);
          e.y = 32'(k / IW);
          e.c = plan_c0[k];
          if (plan_mask[k][0]) q0.push_back(e);
          e.c = plan_c1[k];
          if (plan_mask[k][1]) q1.push_back(e);
        end
      end
    end
    pend_hit = 2'b00;
    pend_col = '0;
    if (q0.size() != 0 && q0[0].x == check_x && q0[0].y == check_y) begin
      pend_hit[0] = 1'b1;
      pend_col[23:0] = q0[0].c;
      q0.delete(0);
    end
    if (q1.size() != 0 && q1[0].x == check_x && q1[0].y == check_y) begin
      pend_hit[1] = 1'b1;
      pend_col[47:24] = q1[0].c;
      q1.delete(0);
    end
  end

  initial begin
    q_hit = '0;
    q_colour = '0;
    forever begin
      @(posedge clk);
      #1;
      q_hit = pend_hit | inj;
      q_colour = pend_col;
    end
  end

  // Output monitor: pixel order, content, markers, latency and broadcast.
  int exp_idx = 0, s_gen = 0, cyc = 0, seek_cyc = 0;
  bit in_seek = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (gen != s_gen) begin
      s_gen = gen;
      exp_idx = 0;
      in_seek = 0;
    end
    if (mon_en) begin
      if (pix_valid) begin
        if (exp_idx >= NPIX) begin
          check_eq("extra_pixel", 64'(exp_idx), 64'(NPIX - 1));
        end else begin
          if (in_seek) begin
            in_seek = 0;
            check_eq("latency", 64'(cyc - seek_cyc), 64'(plan_mask[exp_idx] != 2'b00 ? 2 : TO));
          end
          check_eq("pix_colour", 64'(pix_colour), 64'(exp_colour(exp_idx)));
          check_eq("pix_sof", 64'(pix_sof), 64'(exp_idx == 0));
          check_eq("pix_eol", 64'(pix_eol), 64'((exp_idx % IW) == IW - 1));
          check_eq("park_x", 64'(check_x), 64'(PARK));
          check_eq("park_y", 64'(check_y), 64'(PARK));
          if (pix_ready) begin
            check_eq("frame_done_acc", 64'(frame_done), 64'(exp_idx == NPIX - 1));
            exp_idx++;
          end else begin
            check_eq("frame_done_hold", 64'(frame_done), 64'(0));
          end
        end
      end else begin
        check_eq("frame_done_quiet", 64'(frame_done), 64'(0));
        if (busy) begin
          if (!in_seek) begin
            in_seek = 1;
            seek_cyc = cyc;
          end
          check_eq("seek_x", 64'(check_x), 64'(exp_idx % IW));
          check_eq("seek_y", 64'(check_y), 64'(exp_idx / IW));
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    mon_en = 0;
    plan_valid = 0;
    gen++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_terr = 0;
    exp_herr = 0;
  endtask

  // style: 0 all queue0, 1 random masks, 2 double hit at (1,0), 3 no hit at (2,0)
  // rmode: 0 ready high, 1 random ready, 2 ready low 5 cycles at pixel (1,1)
  // stop_at: raster index at which reset is asserted in OUT, or -1
  task automatic run_frame(input int style, input int rmode, input int stop_at);
    int n = 0;
    int hold = 0;
    bit done = 0;
    bit aborted = 0;
    for (int k = 0; k < NPIX; k++) begin
      int r;
      plan_c0[k] = 24'($urandom);
      plan_c1[k] = 24'($urandom);
      case (style)
        1: begin
          r = int'($urandom_range(0, 7));
          plan_mask[k] = (r == 0) ? 2'b00 : 2'((r % 3) + 1);
        end
        2: begin
          plan_mask[k] = (k == 1) ? 2'b11 : 2'b01;
          if (k == 1) begin
            plan_c0[k] = 24'h111111;
            plan_c1[k] = 24'h222222;
          end
        end
        3: plan_mask[k] = (k == 2) ? 2'b00 : 2'b01;
        default: plan_mask[k] = 2'b01;
      endcase
      if (plan_mask[k] == 2'b11) exp_herr = 1;
      if (plan_mask[k] == 2'b00) exp_terr = 1;
    end
    plan_valid = 1;
    gen++;
    mon_en = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    pix_ready = 1'b1;
    while (!done && !aborted && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (stop_at >= 0 && pix_valid && exp_idx == stop_at) begin
        reset = 1'b1;
        start = 1'b1;
        pix_ready = 1'b1;
        mon_en = 0;
        plan_valid = 0;
        gen++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        pix_ready = 1'b0;
        exp_terr = 0;
        exp_herr = 0;
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_check_x", 64'(check_x), 64'(PARK));
        check_eq("rst_check_y", 64'(check_y), 64'(PARK));
        check_eq("rst_pix_valid", 64'(pix_valid), 64'(0));
        aborted = 1;
      end else if (exp_idx == NPIX && !busy) begin
        done = 1;
        start = 1'b0;
      end else begin
        start = busy && ($urandom_range(0, 5) == 0);
        case (rmode)
          1: pix_ready = ($urandom_range(0, 2) != 0);
          2: begin
            if (pix_valid && exp_idx == 5 && hold < 5) begin
              pix_ready = 1'b0;
              hold++;
            end else begin
              pix_ready = 1'b1;
            end
          end
          default: pix_ready = 1'b1;
        endcase
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check_eq("frame_complete", 64'(done), 64'(1));
      check_eq("end_busy", 64'(busy), 64'(0));
      check_eq("end_valid", 64'(pix_valid), 64'(0));
      check_eq("end_park", 64'(check_x), 64'(PARK));
      check_eq("timeout_err", 64'(timeout_err), 64'(exp_terr));
      check_eq("hit_err", 64'(hit_err), 64'(exp_herr));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_check_x", 64'(check_x), 64'(PARK));
    check_eq("reset_check_y", 64'(check_y), 64'(PARK));
    check_eq("reset_pix_valid", 64'(pix_valid), 64'(0));
    check_eq("reset_pix_colour", 64'(pix_colour), 64'(0));
    check_eq("reset_pix_sof", 64'(pix_sof), 64'(0));
    check_eq("reset_pix_eol", 64'(pix_eol), 64'(0));
    check_eq("reset_frame_done", 64'(frame_done), 64'(0));
    check_eq("reset_busy", 64'(busy), 64'(0));
    check_eq("reset_timeout_err", 64'(timeout_err), 64'(0));
    check_eq("reset_hit_err", 64'(hit_err), 64'(0));

    run_frame(0, 0, -1);
    run_frame(2, 0, -1);
    do_reset();
    run_frame(3, 0, -1);

    // stray hit while idle
    @(negedge clk);
    inj = 2'b01;
    @(negedge clk);
    inj = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("stray_hit_err", 64'(hit_err), 64'(1));
    check_eq("stray_terr_sticky", 64'(timeout_err), 64'(1));
    check_eq("stray_busy", 64'(busy), 64'(0));
    do_reset();
    @(negedge clk);
    check_eq("clr_hit_err", 64'(hit_err), 64'(0));
    check_eq("clr_timeout_err", 64'(timeout_err), 64'(0));

    run_frame(0, 2, -1);
    run_frame(0, 0, 3);
    run_frame(0, 0, -1);
    for (int f = 0; f < 6; f++) run_frame(1, 1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
